param_frame_parser: RTL and testbench



---
 rtl/param_frame_pkg.sv | 23 ++
 rtl/param_frame_ack_tx.sv | 47 ++++
 rtl/param_frame_parser.sv | 177 +++++++++++++++++
 tb/tb_param_frame_parser.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_frame_pkg.sv
// Shared types and constants for the parameter frame parser and its ack buffer.
// Optional ack path is enabled with PARAM_FRAME_ACK_EN.
package param_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ID,
    ST_GET_VAL,
    ST_GET_SUM,
    ST_LOAD,
    ST_APPLY
  } state_e;

  localparam logic [7:0] HEADER_DEFAULT = 8'hAA;
  localparam logic [7:0] ACK_CODE       = 8'h06;
  localparam logic [7:0] NAK_CODE       = 8'h15;
  localparam logic [7:0] PARAM_ID_IDLE  = 8'h00;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/param_frame_ack_tx.sv
// One-entry ack/nak byte buffer toward the host UART transmitter.
// Only compiled when PARAM_FRAME_ACK_EN is defined.
`ifdef PARAM_FRAME_ACK_EN
module param_frame_ack_tx
  import param_frame_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ok_i,
  input  logic       err_i,
  input  logic       tx_ready_i,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o
);

  logic       valid_q, valid_d;
  logic [7:0] data_q,  data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && tx_ready_i) valid_d = 1'b0;
    // A pending NAK is never replaced by an ACK; an error always lands.
    if (err_i) begin
      valid_d = 1'b1;
      data_d  = NAK_CODE;
    end else if (ok_i && !(valid_d && data_q == NAK_CODE)) begin
      valid_d = 1'b1;
      data_d  = ACK_CODE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign tx_data_o  = data_q;
  assign tx_valid_o = valid_q;

endmodule
`endif

// File: rtl/param_frame_parser.sv
// Assembles HEADER/ID/V3..V0/SUM frames from the UART byte stream and presents
// id/value glitch-safely. PARAM_FRAME_ACK_EN adds the tx ack byte port.
module param_frame_parser
  import param_frame_pkg::*;
#(
  parameter logic [7:0]  HEADER         = HEADER_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned HOLD_CYCLES    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  parameter_id,
  output logic [31:0] parameter_value,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [7:0]  err_cnt
`ifdef PARAM_FRAME_ACK_EN
  ,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
`endif
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_e            state_q, state_d;
  logic [7:0]        id_q, id_d;
  logic [31:0]       shadow_q, shadow_d;
  logic [7:0]        sum_q, sum_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [3:0]        hold_q, hold_d;
  logic [7:0]        pid_q, pid_d;
  logic [31:0]       pval_q, pval_d;
  logic              ok_q, ok_d;
  logic              err_q, err_d;
  logic [7:0]        ecnt_q, ecnt_d;
  logic              in_frame;

  assign in_frame = (state_q == ST_GET_ID) || (state_q == ST_GET_VAL) || (state_q == ST_GET_SUM);

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    shadow_d = shadow_q;
    sum_d    = sum_q;
    bcnt_d   = bcnt_q;
    to_d     = to_q;
    hold_d   = hold_q;
    pid_d    = pid_q;
    pval_d   = pval_q;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    ecnt_d   = ecnt_q;

    // Idle-gap watchdog; a byte on the expiry cycle still counts as received.
    if (in_frame) begin
      if (rx_valid) begin
        to_d = '0;
      end else if (to_q == TO_LAST) begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end else begin
        to_d = to_q + TO_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (rx_valid && rx_data == HEADER) begin
          state_d = ST_GET_ID;
          to_d    = '0;
        end
      end
      ST_GET_ID: begin
        if (rx_valid) begin
          id_d    = rx_data;
          sum_d   = rx_data;
          bcnt_d  = 2'd0;
          state_d = ST_GET_VAL;
        end
      end
      ST_GET_VAL: begin
        if (rx_valid) begin
          shadow_d = {shadow_q[23:0], rx_data};
          sum_d    = sum_q + rx_data;
          bcnt_d   = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) state_d = ST_GET_SUM;
        end
      end
      ST_GET_SUM: begin
        if (rx_valid) begin
          // Value register is written on entry to LOAD so it is stable a cycle before the id.
          if (rx_data == sum_q && id_q != PARAM_ID_IDLE) begin
            pval_d  = shadow_q;
            state_d = ST_LOAD;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_LOAD: begin
        pid_d   = id_q;
        ok_d    = 1'b1;
        hold_d  = HOLD_LAST;
        state_d = ST_APPLY;
      end
      ST_APPLY: begin
        if (hold_q == 4'd0) begin
          pid_d   = PARAM_ID_IDLE;
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q == ST_LOAD || state_q == ST_APPLY) && rx_valid) err_d = 1'b1;
    if (err_d) ecnt_d = sat_inc8(ecnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      id_q     <= PARAM_ID_IDLE;
      shadow_q <= '0;
      sum_q    <= '0;
      bcnt_q   <= '0;
      to_q     <= '0;
      hold_q   <= '0;
      pid_q    <= PARAM_ID_IDLE;
      pval_q   <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      ecnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      shadow_q <= shadow_d;
      sum_q    <= sum_d;
      bcnt_q   <= bcnt_d;
      to_q     <= to_d;
      hold_q   <= hold_d;
      pid_q    <= pid_d;
      pval_q   <= pval_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      ecnt_q   <= ecnt_d;
    end
  end

  assign parameter_id    = pid_q;
  assign parameter_value = pval_q;
  assign frame_ok        = ok_q;
  assign frame_err       = err_q;
  assign err_cnt         = ecnt_q;

`ifdef PARAM_FRAME_ACK_EN
  param_frame_ack_tx u_ack (
    .clk        (clk),
    .rst_n      (rst_n),
    .ok_i       (ok_d),
    .err_i      (err_d),
    .tx_ready_i (tx_ready),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid)
  );
`endif

endmodule

// File: tb/tb_param_frame_parser.sv
// Self-checking bench for param_frame_parser: directed frames plus randomized frames
// checked against a frame-level reference model.
module tb_param_frame_parser;

  localparam int HOLD = 2;
  localparam int TO   = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  parameter_id;
  logic [31:0] parameter_value;
  logic        frame_ok, frame_err;
  logic [7:0]  err_cnt;
`ifdef PARAM_FRAME_ACK_EN
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
`endif

  int checks = 0, failures = 0;
  int ok_seen = 0, err_seen = 0, order_viol = 0;
  int model_oks = 0, model_err_total = 0, model_ecnt = 0;
  logic [31:0] model_val = 32'h0;
  logic [7:0]  prev_id = 8'h00;
  logic [31:0] prev_val = 32'h0;

  param_frame_parser #(.HEADER(8'hAA), .TIMEOUT_CYCLES(TO), .HOLD_CYCLES(HOLD)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .parameter_id    (parameter_id),
    .parameter_value (parameter_value),
    .frame_ok        (frame_ok),
    .frame_err       (frame_err),
    .err_cnt         (err_cnt)
`ifdef PARAM_FRAME_ACK_EN
    ,
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready)
`endif
  );

  always #5 clk = ~clk;

  // Pulse counters and the "value never moves while id is asserted" rule.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_ok)  ok_seen  <= ok_seen + 1;
      if (frame_err) err_seen <= err_seen + 1;
      if (prev_id != 8'h00 && parameter_value != prev_val) order_viol <= order_viol + 1;
    end
    prev_id  <= parameter_id;
    prev_val <= parameter_value;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic note_err();
    model_err_total++;
    if (model_ecnt < 255) model_ecnt++;
  endtask

  // Sends a full frame; returns at the negedge one cycle after the SUM byte is taken.
  task automatic send_frame(input logic [7:0] id, input logic [31:0] v, input logic [7:0] sum, input int maxgap);
    logic [7:0] bytes [7];
    bytes[0] = 8'hAA; bytes[1] = id;
    bytes[2] = v[31:24]; bytes[3] = v[23:16]; bytes[4] = v[15:8]; bytes[5] = v[7:0];
    bytes[6] = sum;
    for (int i = 0; i < 7; i++) begin
      send(bytes[i]);
      if (i < 6 && maxgap > 0) idle($urandom_range(0, maxgap));
    end
  endtask

  function automatic logic [7:0] ref_sum(input logic [7:0] id, input logic [31:0] v);
    int s;
    s = id + v[31:24] + v[23:16] + v[15:8] + v[7:0];
    return 8'(s % 256);
  endfunction

  task automatic post_sum(input bit app, input logic [7:0] id, input logic [31:0] v);
    if (app) begin
      chk("val_at_p1", parameter_value, v);
      chk("id_idle_at_p1", {24'h0, parameter_id}, 32'h0);
      @(negedge clk);
      chk("id_on_at_p2", {24'h0, parameter_id}, {24'h0, id});
      chk("ok_pulse", {31'h0, frame_ok}, 32'h1);
      for (int i = 1; i < HOLD; i++) begin
        @(negedge clk);
        chk("id_hold", {24'h0, parameter_id}, {24'h0, id});
        chk("ok_single", {31'h0, frame_ok}, 32'h0);
      end
      @(negedge clk);
      chk("id_off", {24'h0, parameter_id}, 32'h0);
      chk("val_retained", parameter_value, v);
      model_val = v;
      model_oks++;
    end else begin
      chk("err_pulse", {31'h0, frame_err}, 32'h1);
      chk("id_stays_idle", {24'h0, parameter_id}, 32'h0);
      chk("val_unchanged", parameter_value, model_val);
      note_err();
      @(negedge clk);
      chk("no_ok_on_err", {31'h0, frame_ok}, 32'h0);
    end
  endtask

  initial begin
    logic [7:0]  rid, rsum;
    logic [31:0] rval;
    bit          app;

    idle(3);
    chk("rst_id", {24'h0, parameter_id}, 32'h0);
    chk("rst_val", parameter_value, 32'h0);
    chk("rst_ok", {31'h0, frame_ok}, 32'h0);
    chk("rst_err", {31'h0, frame_err}, 32'h0);
    chk("rst_ecnt", {24'h0, err_cnt}, 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Good frame
    send_frame(8'h01, 32'h00053E2D, 8'h71, 0);
    post_sum(1'b1, 8'h01, 32'h00053E2D);
    chk("ecnt_good", {24'h0, err_cnt}, 32'h0);
`ifdef PARAM_FRAME_ACK_EN
    idle(50);
    chk("ack_valid", {31'h0, tx_valid}, 32'h1);
    chk("ack_data", {24'h0, tx_data}, 32'h06);
    tx_ready = 1'b1;
    idle(1);
    tx_ready = 1'b0;
    chk("ack_drained", {31'h0, tx_valid}, 32'h0);
`endif

    // Bad checksum
    send_frame(8'h01, 32'h00053E2D, 8'h70, 0);
    post_sum(1'b0, 8'h01, 32'h0);
    chk("ecnt_bad", {24'h0, err_cnt}, 32'd1);
`ifdef PARAM_FRAME_ACK_EN
    idle(2);
    chk("nak_valid", {31'h0, tx_valid}, 32'h1);
    chk("nak_data", {24'h0, tx_data}, 32'h15);
    tx_ready = 1'b1;
`endif

    // Timeout exactly at TO idle cycles
    send(8'hAA); send(8'h12);
    idle(TO - 1);
    chk("no_timeout_early", {31'h0, frame_err}, 32'h0);
    idle(1);
    chk("timeout_err", {31'h0, frame_err}, 32'h1);
    note_err();
    idle(1);
    chk("ecnt_timeout", {24'h0, err_cnt}, 32'(model_ecnt));
    send_frame(8'h12, 32'h1, 8'h13, 0);
    post_sum(1'b1, 8'h12, 32'h1);

    // Byte arriving on the timeout cycle itself is taken
    send(8'hAA); send(8'h34);
    idle(TO - 1);
    send(8'h00);
    chk("byte_wins", {31'h0, frame_err}, 32'h0);
    send(8'h00); send(8'h00); send(8'h02); send(8'h36);
    post_sum(1'b1, 8'h34, 32'h2);

    // Noise then reserved-ID-free mismatch, then ID 00
    send(8'h55);
    idle(1);
    chk("noise_silent", {31'h0, frame_err}, 32'h0);
    send(8'hAA); send(8'hAA);
    for (int i = 0; i < 5; i++) send(8'h00);
    post_sum(1'b0, 8'hAA, 32'h0);
    send(8'h00);
    chk("trailing_silent", {31'h0, frame_err}, 32'h0);
    send_frame(8'h00, 32'h0, 8'h00, 0);
    post_sum(1'b0, 8'h00, 32'h0);

    // Overrun: a byte taken during LOAD
    send_frame(8'h21, 32'hCAFE0001, ref_sum(8'h21, 32'hCAFE0001), 0);
    chk("ovr_val_p1", parameter_value, 32'hCAFE0001);
    rx_data = 8'h5A; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("ovr_err", {31'h0, frame_err}, 32'h1);
    chk("ovr_id_on", {24'h0, parameter_id}, 32'h21);
    chk("ovr_ok", {31'h0, frame_ok}, 32'h1);
    note_err(); model_oks++;
    idle(HOLD - 1);
    chk("ovr_id_hold", {24'h0, parameter_id}, 32'h21);
    idle(1);
    chk("ovr_id_off", {24'h0, parameter_id}, 32'h0);
    chk("ovr_val", parameter_value, 32'hCAFE0001);
    model_val = 32'hCAFE0001;
    chk("ovr_ecnt", {24'h0, err_cnt}, 32'(model_ecnt));

    // Randomized frames against the frame-level model
    for (int n = 0; n < 24; n++) begin
      rid  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      rval = $urandom;
      rsum = ref_sum(rid, rval);
      if ($urandom_range(0, 2) == 0) rsum = rsum ^ 8'($urandom_range(1, 255));
      if ($urandom_range(0, 1) == 1) send(8'($urandom_range(0, 8'hA9)));
      app = (rsum == ref_sum(rid, rval)) && (rid != 8'h00);
      send_frame(rid, rval, rsum, 3);
      post_sum(app, rid, rval);
      idle($urandom_range(0, 2));
    end
    chk("rand_ecnt", {24'h0, err_cnt}, 32'(model_ecnt));

    // Asynchronous reset mid-value
    send(8'hAA); send(8'h07); send(8'h11); send(8'h22);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_id", {24'h0, parameter_id}, 32'h0);
    chk("arst_val", parameter_value, 32'h0);
    chk("arst_ecnt", {24'h0, err_cnt}, 32'h0);
    chk("arst_err", {31'h0, frame_err}, 32'h0);
    model_ecnt = 0; model_val = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h33); send(8'h44); send(8'h77);
    idle(TO + 5);
    chk("arst_partial_gone", {24'h0, err_cnt}, 32'h0);
    send_frame(8'h09, 32'h01020304, ref_sum(8'h09, 32'h01020304), 0);
    post_sum(1'b1, 8'h09, 32'h01020304);

    // Saturation of the error counter
    for (int i = 0; i < 258; i++) begin
      send_frame(8'h00, 32'h0, 8'h00, 0);
      note_err();
    end
    idle(2);
    chk("ecnt_saturated", {24'h0, err_cnt}, 32'(model_ecnt));

    idle(3);
    chk("ok_pulses_total", 32'(ok_seen), 32'(model_oks));
    chk("err_pulses_total", 32'(err_seen), 32'(model_err_total));
    chk("value_stable_under_id", 32'(order_viol), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
